// File: rtl/db15_pkg.sv
// Shared types and constants for the DB15 (74HC165 chain) joystick scanner.
package db15_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, UPDATE} state_e;

  localparam int unsigned LOAD_TICKS = 2;
  localparam int unsigned BITS       = 32;

  localparam int unsigned BTN_R = 0;
  localparam int unsigned BTN_L = 1;
  localparam int unsigned BTN_D = 2;
  localparam int unsigned BTN_U = 3;
  localparam int unsigned BTN_A = 4;
  localparam int unsigned BTN_B = 5;

endpackage

// File: rtl/db15_tick_gen.sv
// Tick divider (CLK_DIV clks per tick) and frame counter (FRAME_TICKS ticks per scan period).
module db15_tick_gen #(
  parameter int unsigned CLK_DIV     = 8,
  parameter int unsigned FRAME_TICKS = 1024
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic frame_start
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned FRM_W = $clog2(FRAME_TICKS);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(FRAME_TICKS - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [FRM_W-1:0] frm_q, frm_d;

  assign tick        = (div_q == DIV_MAX);
  assign frame_start = tick && (frm_q == '0);

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    frm_d = frm_q;
    if (tick) begin
      frm_d = (frm_q == FRM_MAX) ? '0 : frm_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      frm_q <= '0;
    end else begin
      div_q <= div_d;
      frm_q <= frm_d;
    end
  end

endmodule

// File: rtl/db15_joy_scanner.sv
// Scans the UserIO DB15 adapter's 74HC165 chain and publishes two active-high player words.
// Optional DB15_DEBOUNCE_EN: publish only when two consecutive scans agree.
module db15_joy_scanner
  import db15_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 8,
  parameter int unsigned FRAME_TICKS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        valid
);

  localparam int unsigned LC_W  = $clog2(LOAD_TICKS);
  localparam int unsigned BIT_W = $clog2(BITS);
  localparam logic [LC_W-1:0]  LC_MAX  = LC_W'(LOAD_TICKS - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(BITS - 1);

  logic tick, frame_start;

  db15_tick_gen #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_TICKS(FRAME_TICKS)
  ) u_tick_gen (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .frame_start(frame_start)
  );

  state_e            state_q, state_d;
  logic [LC_W-1:0]   load_cnt_q, load_cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              phase_q, phase_d;
  logic [BITS-1:0]   sh_q, sh_d;
  logic [1:0]        sync_q;
  logic              joy_clk_q, joy_clk_d;
  logic              joy_load_q, joy_load_d;
  logic [15:0]       j1_q, j1_d, j2_q, j2_d;
  logic              valid_q, valid_d;
`ifdef DB15_DEBOUNCE_EN
  logic [BITS-1:0]   prev_q, prev_d;
`endif

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    sh_d       = sh_q;
    joy_clk_d  = joy_clk_q;
    joy_load_d = joy_load_q;
    j1_d       = j1_q;
    j2_d       = j2_q;
    valid_d    = 1'b0;
`ifdef DB15_DEBOUNCE_EN
    prev_d     = prev_q;
`endif
    case (state_q)
      IDLE: begin
        joy_load_d = 1'b1;
        joy_clk_d  = 1'b0;
        if (frame_start) begin
          state_d    = LOAD;
          joy_load_d = 1'b0;
          load_cnt_d = '0;
        end
      end
      LOAD: begin
        if (tick) begin
          if (load_cnt_q == LC_MAX) begin
            state_d    = SHIFT;
            joy_load_d = 1'b1;
            bit_d      = '0;
            phase_d    = 1'b0;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      SHIFT: begin
        // Sampling on the rising-edge tick keeps data a full tick past the previous falling edge.
        if (tick) begin
          if (!phase_q) begin
            sh_d[bit_q] = sync_q[1];
            joy_clk_d   = 1'b1;
            phase_d     = 1'b1;
          end else begin
            joy_clk_d = 1'b0;
            phase_d   = 1'b0;
            if (bit_q == BIT_MAX) begin
              state_d = UPDATE;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      UPDATE: begin
        state_d = IDLE;
`ifdef DB15_DEBOUNCE_EN
        prev_d = sh_q;
        if (sh_q == prev_q) begin
          j1_d    = ~sh_q[15:0];
          j2_d    = ~sh_q[31:16];
          valid_d = 1'b1;
        end
`else
        j1_d    = ~sh_q[15:0];
        j2_d    = ~sh_q[31:16];
        valid_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      bit_q      <= '0;
      phase_q    <= 1'b0;
      sh_q       <= '0;
      sync_q     <= '1;
      joy_clk_q  <= 1'b0;
      joy_load_q <= 1'b1;
      j1_q       <= '0;
      j2_q       <= '0;
      valid_q    <= 1'b0;
`ifdef DB15_DEBOUNCE_EN
      prev_q     <= '1;
`endif
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      sh_q       <= sh_d;
      sync_q     <= {sync_q[0], JOY_DATA};
      joy_clk_q  <= joy_clk_d;
      joy_load_q <= joy_load_d;
      j1_q       <= j1_d;
      j2_q       <= j2_d;
      valid_q    <= valid_d;
`ifdef DB15_DEBOUNCE_EN
      prev_q     <= prev_d;
`endif
    end
  end

  assign JOY_CLK   = joy_clk_q;
  assign JOY_LOAD  = joy_load_q;
  assign joystick1 = j1_q;
  assign joystick2 = j2_q;
  assign valid     = valid_q;

endmodule
